// File: rtl/rotbuf_pkg.sv
// rotbuf_pkg: shared types and helpers for the rotating register buffer.
package rotbuf_pkg;

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StDrain} rotbuf_state_e;

   localparam int unsigned ROTCNT_W = 16;

   // Buffer slot feeding tap_p slice k (upper side of the seam).
   function automatic int unsigned tap_p_idx(input int unsigned depth, input int unsigned ntap,
                                             input int unsigned k);
      return depth - ntap + k;
   endfunction

   // Buffer slot feeding tap_m slice k (lower side of the seam, mirrored).
   function automatic int unsigned tap_m_idx(input int unsigned ntap, input int unsigned k);
      return ntap - k;
   endfunction

endpackage

// File: rtl/rotbuf_rotator.sv
// rotbuf_rotator: combinational barrel rotator, out[i] = in[(i + amt) mod DEPTH],
// with an optional single-slot overwrite applied after the rotation.
module rotbuf_rotator
   import rotbuf_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned SHIFT_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0][DATA_W-1:0] din_i,
   input  logic [SHIFT_W-1:0]           amt_i,
   input  logic                         ins_en_i,
   input  logic [SHIFT_W-1:0]           ins_idx_i,
   input  logic [DATA_W-1:0]            ins_data_i,
   output logic [DEPTH-1:0][DATA_W-1:0] dout_o
);

   logic [DEPTH-1:0][DATA_W-1:0] stg [SHIFT_W+1];

   assign stg[0] = din_i;

   // Stage s rotates by 2**s; stage amounts add modulo DEPTH, so non-power-of-two
   // depths work as long as amt_i < DEPTH.
   for (genvar s = 0; s < SHIFT_W; s++) begin : g_stage
      localparam int unsigned Step = (2 ** s) % DEPTH;
      for (genvar i = 0; i < DEPTH; i++) begin : g_slot
         localparam int unsigned Src = (i + Step) % DEPTH;
         assign stg[s+1][i] = amt_i[s] ? stg[s][SHIFT_W'(Src)] : stg[s][i];
      end
   end

   // Final rotated vector with optional slot overwrite.
   always_comb begin
      dout_o = stg[SHIFT_W];
      if (ins_en_i) begin
         dout_o[ins_idx_i] = ins_data_i;
      end
   end

endmodule

// File: rtl/rotbuf.sv
// rotbuf: rotating register buffer with load/run/drain streaming and seam taps.
// Optional macro ROTBUF_TAP_REG_EN registers the taps from next-state contents.
module rotbuf
   import rotbuf_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned NTAP    = 3,
   parameter int unsigned SHIFT_W = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_start,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_data,
   input  logic                   rot_valid,
   output logic                   rot_ready,
   input  logic [SHIFT_W-1:0]     rot_amt,
   input  logic                   rot_ins,
   input  logic [DATA_W-1:0]      rot_data,
   input  logic                   drain_start,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [NTAP*DATA_W-1:0] tap_p,
   output logic [NTAP*DATA_W-1:0] tap_m,
   output logic [ROTCNT_W-1:0]    rot_count,
   output logic                   busy
);

   localparam logic [SHIFT_W-1:0] LastIdx = SHIFT_W'(DEPTH - 1);

   rotbuf_state_e                state_q, state_d;
   logic [SHIFT_W-1:0]           cnt_q, cnt_d;
   logic [ROTCNT_W-1:0]          rot_count_q, rot_count_d;
   logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;

   logic [SHIFT_W-1:0]           r_amt;
   logic                         r_ins_en;
   logic [SHIFT_W-1:0]           r_ins_idx;
   logic [DATA_W-1:0]            r_ins_data;
   logic [DEPTH-1:0][DATA_W-1:0] r_out;

   rotbuf_rotator #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .SHIFT_W(SHIFT_W)
   ) u_rotator (
      .din_i     (mem_q),
      .amt_i     (r_amt),
      .ins_en_i  (r_ins_en),
      .ins_idx_i (r_ins_idx),
      .ins_data_i(r_ins_data),
      .dout_o    (r_out)
   );

   // Next-state: FSM transitions, rotator operand select and buffer update.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rot_count_d = rot_count_q;
      mem_d       = mem_q;
      r_amt       = SHIFT_W'(1);
      r_ins_en    = 1'b0;
      r_ins_idx   = LastIdx;
      r_ins_data  = in_data;
      unique case (state_q)
         StIdle: begin
            if (load_start) begin
               state_d     = StLoad;
               cnt_d       = '0;
               rot_count_d = '0;
            end
         end
         StLoad: begin
            // A load beat is a rotate-by-1 with the wrapped slot replaced by the new word.
            r_ins_en = 1'b1;
            if (in_valid) begin
               mem_d = r_out;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LastIdx) begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            r_amt      = rot_amt;
            r_ins_en   = rot_ins;
            r_ins_idx  = LastIdx - rot_amt;
            r_ins_data = rot_data;
            if (rot_valid) begin
               mem_d = r_out;
               if (rot_count_q != '1) begin
                  rot_count_d = rot_count_q + 1'b1;
               end
            end
            if (load_start) begin
               state_d     = StLoad;
               cnt_d       = '0;
               rot_count_d = '0;
            end else if (drain_start) begin
               state_d = StDrain;
               cnt_d   = '0;
            end
         end
         StDrain: begin
            if (out_ready) begin
               mem_d = r_out;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LastIdx) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, counters and buffer contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         rot_count_q <= '0;
         mem_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rot_count_q <= rot_count_d;
         mem_q       <= mem_d;
      end
   end

   assign in_ready  = (state_q == StLoad);
   assign rot_ready = (state_q == StRun);
   assign out_valid = (state_q == StDrain);
   assign busy      = (state_q != StIdle);
   assign out_data  = out_valid ? mem_q[0] : '0;
   assign rot_count = rot_count_q;

`ifdef ROTBUF_TAP_REG_EN
   logic [NTAP-1:0][DATA_W-1:0] tap_p_q, tap_m_q;

   for (genvar k = 0; k < NTAP; k++) begin : g_tap_reg
      localparam int unsigned PIdx = tap_p_idx(DEPTH, NTAP, k);
      localparam int unsigned MIdx = tap_m_idx(NTAP, k);
      // Taps sampled from next-state contents so they line up with mem_q.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            tap_p_q[k] <= '0;
            tap_m_q[k] <= '0;
         end else begin
            tap_p_q[k] <= mem_d[SHIFT_W'(PIdx)];
            tap_m_q[k] <= mem_d[SHIFT_W'(MIdx)];
         end
      end
   end

   assign tap_p = tap_p_q;
   assign tap_m = tap_m_q;
`else
   logic [NTAP-1:0][DATA_W-1:0] tap_p_w, tap_m_w;

   for (genvar k = 0; k < NTAP; k++) begin : g_tap_comb
      localparam int unsigned PIdx = tap_p_idx(DEPTH, NTAP, k);
      localparam int unsigned MIdx = tap_m_idx(NTAP, k);
      assign tap_p_w[k] = mem_q[SHIFT_W'(PIdx)];
      assign tap_m_w[k] = mem_q[SHIFT_W'(MIdx)];
   end

   assign tap_p = tap_p_w;
   assign tap_m = tap_m_w;
`endif

endmodule

// File: tb/tb_rotbuf.sv
// tb_rotbuf: directed and random checks of rotbuf against an array-level reference model.
module tb_rotbuf;

   localparam int DW = 32;
   localparam int DEP = 16;
   localparam int NT = 3;

   logic          clk, rst;
   logic          load_start, in_valid, in_ready;
   logic [DW-1:0] in_data;
   logic          rot_valid, rot_ready;
   logic [3:0]    rot_amt;
   logic          rot_ins;
   logic [DW-1:0] rot_data;
   logic          drain_start, out_valid, out_ready;
   logic [DW-1:0] out_data;
   logic [NT*DW-1:0] tap_p, tap_m;
   logic [15:0]   rot_count;
   logic          busy;

   rotbuf dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .rot_valid  (rot_valid),
      .rot_ready  (rot_ready),
      .rot_amt    (rot_amt),
      .rot_ins    (rot_ins),
      .rot_data   (rot_data),
      .drain_start(drain_start),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .tap_p      (tap_p),
      .tap_m      (tap_m),
      .rot_count  (rot_count),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: buffer contents, mode (0 idle, 1 load, 2 run, 3 drain), counters.
   logic [31:0] m [DEP];
   int          mst;
   int          bcnt;
   int          mcnt;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void mrot(input int amt, input bit ins, input logic [31:0] d);
      logic [31:0] t [DEP];
      for (int i = 0; i < DEP; i++) t[i] = m[(i + amt) % DEP];
      if (ins) t[DEP-1-amt] = d;
      for (int i = 0; i < DEP; i++) m[i] = t[i];
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < DEP; i++) m[i] = '0;
      mst  = 0;
      bcnt = 0;
      mcnt = 0;
   endfunction

   // Advance the model by one clock edge using the currently driven inputs.
   function automatic void model_step();
      case (mst)
         0: if (load_start) begin
            mst = 1; bcnt = 0; mcnt = 0;
         end
         1: if (in_valid) begin
            for (int i = 0; i < DEP - 1; i++) m[i] = m[i+1];
            m[DEP-1] = in_data;
            bcnt++;
            if (bcnt == DEP) mst = 2;
         end
         2: begin
            if (rot_valid) begin
               mrot(int'(rot_amt), rot_ins, rot_data);
               if (mcnt < 65535) mcnt++;
            end
            if (load_start) begin
               mst = 1; bcnt = 0; mcnt = 0;
            end else if (drain_start) begin
               mst = 3; bcnt = 0;
            end
         end
         3: if (out_ready) begin
            mrot(1, 1'b0, '0);
            bcnt++;
            if (bcnt == DEP) mst = 0;
         end
         default: mst = 0;
      endcase
   endfunction

   task automatic check_all(input string tag);
      for (int k = 0; k < NT; k++) begin
         chk({tag, "/tap_p"}, tap_p[k*DW +: DW], m[DEP-NT+k]);
         chk({tag, "/tap_m"}, tap_m[k*DW +: DW], m[NT-k]);
      end
      chk({tag, "/rot_count"}, {16'h0, rot_count}, mcnt);
      chk({tag, "/busy"}, busy, mst != 0);
      chk({tag, "/in_ready"}, in_ready, mst == 1);
      chk({tag, "/rot_ready"}, rot_ready, mst == 2);
      chk({tag, "/out_valid"}, out_valid, mst == 3);
      if (mst == 3) chk({tag, "/out_data"}, out_data, m[0]);
   endtask

   task automatic idle_inputs();
      load_start = 0; in_valid = 0; in_data = '0;
      rot_valid = 0; rot_amt = '0; rot_ins = 0; rot_data = '0;
      drain_start = 0; out_ready = 0;
   endtask

   // One clock: drive inputs, step the model, let the edge pass, compare.
   task automatic cyc(input bit ls, input bit iv, input logic [31:0] id, input bit rv,
                      input logic [3:0] ra, input bit ri, input logic [31:0] rd,
                      input bit ds, input bit ordy, input string tag);
      load_start = ls; in_valid = iv; in_data = id;
      rot_valid = rv; rot_amt = ra; rot_ins = ri; rot_data = rd;
      drain_start = ds; out_ready = ordy;
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic load_ramp();
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, "load_start");
      for (int i = 0; i < DEP; i++) cyc(0, 1, i, 0, 0, 0, 0, 0, 0, "load_beat");
   endtask

   task automatic expect_taps(input string tag, input int p0, input int p1, input int p2,
                              input int m0, input int m1, input int m2);
      chk({tag, "/p0"}, tap_p[0*DW +: DW], p0);
      chk({tag, "/p1"}, tap_p[1*DW +: DW], p1);
      chk({tag, "/p2"}, tap_p[2*DW +: DW], p2);
      chk({tag, "/m0"}, tap_m[0*DW +: DW], m0);
      chk({tag, "/m1"}, tap_m[1*DW +: DW], m1);
      chk({tag, "/m2"}, tap_m[2*DW +: DW], m2);
   endtask

   // Drain with out_ready on every other cycle, checking each beat against a fixed list.
   task automatic drain_toggle(input logic [31:0] exp [DEP], input string tag);
      int beats = 0;
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, {tag, "/start"});
      for (int it = 0; it < 4 * DEP && beats < DEP; it++) begin
         if (it % 2 == 1) begin
            chk({tag, "/word"}, out_data, exp[beats]);
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, tag);
            beats++;
         end else begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
         end
      end
      chk({tag, "/beats"}, beats, DEP);
      chk({tag, "/idle"}, busy, 1'b0);
   endtask

   initial begin
      logic [31:0] exp [DEP];
      idle_inputs();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_all("reset");
      chk("reset/out_data", out_data, 0);

      // Commands outside their states are ignored.
      cyc(0, 0, 0, 1, 4'd3, 1, 32'h55, 0, 0, "idle_rot");
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, "idle_drain");

      load_ramp();
      expect_taps("ramp", 13, 14, 15, 3, 2, 1);
      chk("ramp/rot_count", {16'h0, rot_count}, 0);
      chk("ramp/rot_ready", rot_ready, 1'b1);

      cyc(0, 0, 0, 1, 4'd1, 0, 0, 0, 0, "rot1");
      expect_taps("rot1", 14, 15, 0, 4, 3, 2);
      chk("rot1/rot_count", {16'h0, rot_count}, 1);

      load_ramp();
      chk("reload/rot_count", {16'h0, rot_count}, 0);
      cyc(0, 0, 0, 1, 4'd5, 1, 32'hAA, 0, 0, "rot5ins");
      expect_taps("rot5ins", 2, 3, 4, 8, 7, 6);
      for (int j = 0; j < DEP; j++) exp[j] = (j == 10) ? 32'hAA : 32'((j + 5) % DEP);
      drain_toggle(exp, "drain_ins");

      load_ramp();
      for (int j = 0; j < DEP; j++) exp[j] = j;
      drain_toggle(exp, "drain_ramp");
      expect_taps("post_drain", 13, 14, 15, 3, 2, 1);

      // Zero-amount rotate keeps data but counts.
      load_ramp();
      cyc(0, 0, 0, 1, 4'd0, 0, 0, 0, 0, "rot0");
      expect_taps("rot0", 13, 14, 15, 3, 2, 1);
      chk("rot0/rot_count", {16'h0, rot_count}, 1);

      // Reset in the middle of a load.
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, "mid_start");
      for (int i = 0; i < 7; i++) cyc(0, 1, 32'h100 + i, 0, 0, 0, 0, 0, 0, "mid_beat");
      idle_inputs();
      rst = 1'b1;
      model_reset();
      #1;
      check_all("mid_reset");
      expect_taps("mid_reset", 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      load_ramp();
      expect_taps("after_reset", 13, 14, 15, 3, 2, 1);

      // Random traffic over all states.
      for (int it = 0; it < 1500; it++) begin
         cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7), $urandom,
             ($urandom_range(0, 1) == 1), 4'($urandom_range(0, DEP - 1)),
             ($urandom_range(0, 1) == 1), $urandom,
             ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rotbuf.md
# rotbuf

Parametrised rotating register buffer for the iterative solver datapath: stores DEPTH words, streams them in, rotates by any runtime amount 0..DEPTH-1 (optionally overwriting one slot), and exposes symmetric neighbour taps around the buffer seam for the update arithmetic. Adds a load/run/drain state machine with valid/ready streaming and a rotation counter to what the fixed-size shift register provides.

## Interface
- DATA_W, 32, word width
- DEPTH, 16, number of entries (>= 2*NTAP+2)
- NTAP, 3, taps per side
- SHIFT_W, $clog2(DEPTH), rotation-amount width
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- load_start  input  1  begin a load (IDLE or RUN only)
- in_valid / in_ready  input / output  1  load stream handshake
- in_data  input  DATA_W  load word
- rot_valid / rot_ready  input / output  1  rotate command handshake
- rot_amt  input  SHIFT_W  rotation amount
- rot_ins  input  1  overwrite slot on rotate
- rot_data  input  DATA_W  overwrite word
- drain_start  input  1  begin drain (RUN only)
- out_valid / out_ready  output / input  1  drain stream handshake
- out_data  output  DATA_W  drain word
- tap_p  output  NTAP*DATA_W  slice k = M[DEPTH-NTAP+k]
- tap_m  output  NTAP*DATA_W  slice k = M[NTAP-k]
- rot_count  output  16  accepted rotations since last load, saturating at 0xFFFF
- busy  output  1  state != IDLE

## Operation
- States IDLE, LOAD, RUN, DRAIN; reset -> IDLE.
- IDLE: load_start -> LOAD, beat counter = 0. drain_start and rot_valid ignored.
- LOAD: in_ready=1. Each accepted beat: M[i]<=M[i+1] for i<DEPTH-1, M[DEPTH-1]<=in_data. After DEPTH beats -> RUN; first word ends in M[0]. rot_count cleared on entry.
- RUN: rot_ready=1. Accepted command: M[i]<=M[(i+rot_amt) mod DEPTH]; if rot_ins, slot DEPTH-1-rot_amt (which receives old M[DEPTH-1]) takes rot_data instead. rot_amt=0 is a no-op on data but counts. rot_count increments per accepted command.
- RUN priority: rotation accepted this cycle is applied; load_start -> LOAD, else drain_start -> DRAIN, effective next cycle.
- DRAIN: out_valid=1, out_data=M[0]. Each accepted beat rotates by 1. After DEPTH beats -> IDLE; contents end identical to entry state.
- All handshake outputs are 0 outside their state. load_start/drain_start in other states ignored.
- Reset at any time: all M, counters, tap registers to 0; state IDLE; in-flight transfer lost.
- Reset values: in_ready=rot_ready=out_valid=busy=0, out_data=0, taps=0, rot_count=0.

## Timing
- Readies and out_valid decoded from state register only (no combinational path from valids).
- Rotation/load/drain beat visible in M and taps the cycle after acceptance.
- Back-to-back acceptance every cycle in all states; load of DEPTH words = DEPTH cycles minimum; RUN reached cycle after final beat.
- out_data valid in same cycle as out_valid; holds while out_ready=0.

## Configuration
- ROTBUF_TAP_REG_EN defined: tap_p/tap_m driven from registers updated from next-state M; taps still track M with one cycle latency after acceptance, registers reset to 0.
- Undefined: taps are direct combinational selects of M, same visible timing; no extra flops.

## Structure
- Package rotbuf_pkg: state enum, ROTCNT_W=16 localparam, tap index helper functions.
- Sub-module rotbuf_rotator: combinational log2(DEPTH)-stage barrel rotator with slot overwrite; shared by LOAD/RUN/DRAIN paths (amount 1 for load/drain).

## Test plan
- Reset: after rst pulse, all outputs 0, busy=0; rot_valid=1 gives rot_ready=0, no change.
- Load words 0..15: tap_p={13,14,15}, tap_m={3,2,1}, state RUN, rot_count=0.
- After load, rotate amt=1 rot_ins=0 -> tap_p={14,15,0}, tap_m={4,3,2}, rot_count=1.
- After load, rotate amt=5 rot_ins=1 rot_data=0xAA -> M[10]=0xAA, M[0]=5, tap_p={2,3,4}, tap_m={8,7,6}.
- Drain with out_ready toggling every other cycle -> out_data 0..15 in order, 16 beats, IDLE, tap_p back to {13,14,15}.
- Assert rst after 7 load beats -> all zero, IDLE; subsequent full load of 0..15 gives expected taps.
